sample_arbiter: RTL
===================

Name: sample_arbiter

Overview:
- Shares one capture FIFO write port between N_SRC channel capture front-ends. Each front-end presents a one-cycle save strobe plus a 32-bit {time, data} word.
- Each source gets a one-entry holding register. Pending words are written round-robin, tagged with the source index.
- A small RUN/DRAIN/IDLE sequencer lets the host stop capture cleanly: all held samples reach the FIFO before idle is reported.
- Sits between the per-channel capture blocks and the shared capture FIFO.

Parameters:
- N_SRC, 4, number of capture sources (2..8).
- DATA_W, 32, width of each source sample word.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  capture enable from host (level).
- i_save  in  N_SRC  per-source one-cycle sample strobe.
- i_data  in  N_SRC*DATA_W  per-source sample words, source k at bits [k*DATA_W +: DATA_W].
- i_fifo_full  in  1  shared FIFO full.
- i_clear_ovf  in  1  one-cycle pulse; clears overflow flags and drop counter.
- o_fifo_wr  out  1  FIFO write strobe.
- o_fifo_wdata  out  ID_W+DATA_W  {source index, sample}. ID_W = max(1, clog2(N_SRC)).
- o_busy  out  N_SRC  holding register k occupied.
- o_ovf  out  N_SRC  sticky per-source overflow.
- o_drop_count  out  CNT_W  saturating count of dropped samples (overflow only).
- o_idle  out  1  sequencer in IDLE.

Behaviour:
- Reset (async):
  - state=IDLE; all holding regs empty; rr_ptr=0; o_ovf=0; o_drop_count=0.
  - o_busy=0; o_idle=1; o_fifo_wr=0; o_fifo_wdata=0.
- Sequencer:
  - IDLE→RUN when i_enable=1.
  - RUN→DRAIN when i_enable=0.
  - DRAIN→IDLE when no holding reg occupied and no grant this cycle.
  - i_enable is ignored in DRAIN.
  - o_idle=1 only in IDLE.
- Accept:
  - Only in RUN. i_save[k]=1 at edge e loads i_data[k] into hold[k]; o_busy[k]=1 after e.
  - Saves in IDLE/DRAIN are discarded silently (no overflow, no count).
- Grant (combinational from registered state):
  - Grant is allowed when state is RUN or DRAIN, i_fifo_full=0 and at least one hold is occupied.
  - The winner is the first occupied index scanning cyclically from rr_ptr.
  - o_fifo_wr=1 and o_fifo_wdata={k, hold[k]} in the same cycle. At the next edge hold[k] empties and rr_ptr=(k+1) mod N_SRC.
  - With no grant, o_fifo_wr=0, o_fifo_wdata holds its last value, and rr_ptr is unchanged.
- Latency: save at edge e → earliest FIFO capture at edge e+1.
- Simultaneous save and grant on the same source at one edge: the held word is written and the new word loads (no overflow). Sustains 1 sample/cycle per source when uncontended.
- Overflow:
  - Triggered by a save on an occupied hold not granted that cycle.
  - The new sample is dropped and the old one is kept.
  - o_ovf[k] is set, o_drop_count increments and saturates at all-ones.
  - Multiple sources overflowing in one cycle add their popcount, saturating.
  - i_clear_ovf in the same cycle as an overflow: clear applies first, then that cycle's overflow sets/counts.
- FIFO full: no writes while i_fifo_full=1; holds persist and rr_ptr is frozen.
- Reset mid-operation discards all held samples immediately.

Decomposition:
- Package sample_arb_pkg holds:
  - state encoding (IDLE, RUN, DRAIN);
  - the ID_W function;
  - a saturating-add helper for the drop counter.
- Sub-module rr_arbiter (N_SRC requests, rr_ptr in, one-hot grant plus index out, purely combinational).
- Holding regs, sequencer and counters stay in sample_arbiter.

Test Plan:
- Reset, i_enable=1, source 2 saves 0xDEADBEEF at edge 5 → o_fifo_wr=1 in cycle after edge 5, o_fifo_wdata={2'd2,0xDEADBEEF}, o_busy=0 after edge 6.
- All 4 sources save in one cycle, rr_ptr=0 → writes in order 0,1,2,3 on four consecutive cycles. Next simultaneous burst also starts at source 0 (rr_ptr wrapped to 0 after granting 3).
- i_fifo_full=1 for 10 cycles with source 1 held; source 1 saves again → o_ovf[1]=1, o_drop_count=1. After full drops, the first held word is written.
- Source 0 saves every cycle, FIFO never full, others idle → one write per cycle, o_ovf=0, no data loss over 100 samples.
- Sources 1 and 3 held, i_enable drops → state DRAIN, both written, o_idle=1 one edge after last write. Saves during DRAIN produce no write and no count.
- Force 70000 overflows, then i_clear_ovf pulsed together with one overflow on source 2 → count saturates at 0xFFFF. After the pulse, count=1 and o_ovf=4'b0100.

Source files
------------

// File: rtl/sample_arb_pkg.sv
// rtl/sample_arb_pkg.sv - shared types and helpers for the sample arbiter
package sample_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Clamps a + b to max; callers keep operands within 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/sample_arbiter_if.sv
// rtl/sample_arbiter_if.sv - host/source/FIFO signal bundle for the sample arbiter
interface sample_arbiter_if
    import sample_arb_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    localparam int ID_W = id_w(N_SRC);

    logic                     i_enable;
    logic [N_SRC-1:0]         i_save;
    logic [N_SRC*DATA_W-1:0]  i_data;
    logic                     i_fifo_full;
    logic                     i_clear_ovf;
    logic                     o_fifo_wr;
    logic [ID_W+DATA_W-1:0]   o_fifo_wdata;
    logic [N_SRC-1:0]         o_busy;
    logic [N_SRC-1:0]         o_ovf;
    logic [CNT_W-1:0]         o_drop_count;
    logic                     o_idle;

    modport master (
        output i_enable, i_save, i_data, i_fifo_full, i_clear_ovf,
        input  o_fifo_wr, o_fifo_wdata, o_busy, o_ovf, o_drop_count, o_idle
    );

    modport slave (
        input  i_enable, i_save, i_data, i_fifo_full, i_clear_ovf,
        output o_fifo_wr, o_fifo_wdata, o_busy, o_ovf, o_drop_count, o_idle
    );

endinterface

// File: rtl/sample_arbiter_rr_arbiter.sv
// rtl/sample_arbiter_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_vld
);

    always_comb begin
        logic [ID_W-1:0] j;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = ID_W'((int'(i_ptr) + i) % N);
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j;
            end
        end
    end

endmodule

// File: rtl/sample_arbiter.sv
// rtl/sample_arbiter.sv - per-source holding registers merged round-robin onto one FIFO write port
module sample_arbiter
    import sample_arb_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sample_arbiter_if.slave bus
);

    localparam int ID_W = id_w(N_SRC);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      hold_q [N_SRC];
    logic [DATA_W-1:0]      hold_d [N_SRC];
    logic [N_SRC-1:0]       vld_q, vld_d;
    logic [N_SRC-1:0]       ovf_q, ovf_d;
    logic [ID_W-1:0]        rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_W+DATA_W-1:0] wdata_q, wdata_d;

    logic [N_SRC-1:0]       gnt_oh;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;
    logic                   gnt_en;
    logic [N_SRC-1:0]       granted;
    logic [N_SRC-1:0]       accept;
    logic [N_SRC-1:0]       ovf_new;
    logic [CNT_W-1:0]       cnt_base;

    rr_arbiter #(.N(N_SRC), .ID_W(ID_W)) u_rr (
        .i_req (vld_q),
        .i_ptr (rr_q),
        .o_gnt (gnt_oh),
        .o_idx (gnt_idx),
        .o_vld (gnt_any)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rr_d     = rr_q;
        wdata_d  = wdata_q;
        ovf_new  = '0;

        gnt_en  = (state_q != ST_IDLE) && !bus.i_fifo_full && gnt_any;
        granted = gnt_en ? gnt_oh : '0;
        accept  = (state_q == ST_RUN) ? bus.i_save : '0;

        // A save on an occupied hold survives only if that hold drains at the same edge.
        for (int k = 0; k < N_SRC; k++) begin
            if (accept[k] && vld_q[k] && !granted[k]) begin
                ovf_new[k] = 1'b1;
            end else if (accept[k]) begin
                hold_d[k] = bus.i_data[k*DATA_W +: DATA_W];
            end
        end
        vld_d = (vld_q & ~granted) | (accept & ~ovf_new);

        if (gnt_en) begin
            wdata_d = {gnt_idx, hold_q[gnt_idx]};
            rr_d    = (gnt_idx == ID_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end

        // Clear takes effect before this cycle's overflows are recorded.
        cnt_base = bus.i_clear_ovf ? '0 : cnt_q;
        ovf_d    = (bus.i_clear_ovf ? '0 : ovf_q) | ovf_new;
        cnt_d    = CNT_W'(sat_add(32'(cnt_base), 32'($countones(ovf_new)),
                                  32'({CNT_W{1'b1}})));

        case (state_q)
            ST_IDLE:  if (bus.i_enable)  state_d = ST_RUN;
            ST_RUN:   if (!bus.i_enable) state_d = ST_DRAIN;
            ST_DRAIN: if (!(|vld_q) && !gnt_en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            vld_q   <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            for (int k = 0; k < N_SRC; k++) hold_q[k] <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            for (int k = 0; k < N_SRC; k++) hold_q[k] <= hold_d[k];
        end
    end

    assign bus.o_fifo_wr    = gnt_en;
    assign bus.o_fifo_wdata = wdata_d;
    assign bus.o_busy       = vld_q;
    assign bus.o_ovf        = ovf_q;
    assign bus.o_drop_count = cnt_q;
    assign bus.o_idle       = (state_q == ST_IDLE);

endmodule
